conf_cmd_receiver: RTL and testbench
====================================

// Module: conf_cmd_receiver
// PURPOSE
//  Host-to-device end of the configuration register link. Takes RX_WIDTH-bit chunks from the
//  host byte interface and assembles address+data write frames for the register file.
//  A reserved address pulses rqst_regs, which starts the register dump on conf_shift_register.
//  Data is LSB-chunk-first, the same ordering conf_shift_register uses when transmitting.
// PARAMETERS
//  NUM_REGS       `__NUM_REGS (16)   number of writable registers; valid addresses 0..NUM_REGS-1
//  DATA_WIDTH     `__DATA_WIDTH (16) register width; must be an integer multiple of RX_WIDTH
//  RX_WIDTH       `__RX_WIDTH (8)    chunk width of the host interface
//  ADDR_WIDTH     4                  width of reg_addr; NUM_REGS <= 2**ADDR_WIDTH
//  RQST_ADDR      8'hFF              address chunk value that means "dump all registers"
//  TIMEOUT_CYCLES 1000000            max idle clk cycles between chunks inside a frame
// PORTS
//  clk        in   1           system clock, all logic on posedge
//  rst        in   1           asynchronous, active-high reset
//  rx_data    in   RX_WIDTH    received chunk; valid only while rx_rdy=1
//  rx_rdy     in   1           one-cycle strobe per chunk; no back-pressure, always accepted
//  reg_addr   out  ADDR_WIDTH  target register index; held until the next write
//  reg_data   out  DATA_WIDTH  assembled register value; held until the next write
//  reg_wr     out  1           one-cycle write strobe qualifying reg_addr/reg_data
//  rqst_regs  out  1           one-cycle pulse: start register dump
//  err_addr   out  1           one-cycle pulse: frame completed with out-of-range address
//  err_timeout out 1           one-cycle pulse: frame aborted by inter-chunk timeout
//  busy       out  1           1 while a frame is in progress (ST_DATA)
// BEHAVIOUR
//  - Reset (async): state=ST_IDLE; reg_addr, reg_data, chunk counter, timer = 0; all pulse
//    outputs and busy = 0. Partial frame discarded; no write is emitted.
//  - Frame = 1 address chunk + CHUNKS = DATA_WIDTH/RX_WIDTH data chunks.
//  - ST_IDLE: on rx_rdy: if rx_data==RQST_ADDR -> rqst_regs=1 next cycle, stay ST_IDLE.
//    Otherwise latch rx_data as frame address (full RX_WIDTH bits kept for range check),
//    counter=CHUNKS-1, timer=0, -> ST_DATA.
//  - ST_DATA: on rx_rdy: shift_data <= {rx_data, shift_data[DATA_WIDTH-1:RX_WIDTH]}, timer=0.
//    If counter!=0: counter-1. If counter==0: -> ST_IDLE; next cycle either
//    reg_wr=1 with reg_addr=addr[ADDR_WIDTH-1:0], reg_data=assembled word (addr < NUM_REGS),
//    or err_addr=1 with reg_addr/reg_data unchanged (addr >= NUM_REGS).
//  - Latency: last data chunk strobe at cycle N -> reg_wr/err_addr at N+1; RQST strobe at N ->
//    rqst_regs at N+1. Pulses are exactly one cycle wide.
//  - Timeout: in ST_DATA without rx_rdy timer increments; at timer==TIMEOUT_CYCLES-1 -> ST_IDLE,
//    err_timeout=1 next cycle, data discarded. rx_rdy in that same cycle wins: chunk consumed,
//    no timeout.
//  - RQST_ADDR inside ST_DATA is ordinary data, not a command.
//  - Back-to-back strobes (every cycle) are fully supported, including a new address chunk in
//    the cycle reg_wr is asserted.
//  - Timer width: $clog2(TIMEOUT_CYCLES)+1, saturating never needed (cleared on exit).
// STRUCTURE
//  - conf_regs_defines.v (shared): __NUM_REGS, __DATA_WIDTH, __RX_WIDTH, __RQST_ADDR,
//    state encodings ST_IDLE=0, ST_DATA=1.
//  - One sub-module: conf_rx_timer (clear, enable, expired output) for the inter-chunk timeout.
//  - Top holds FSM, chunk counter, data shift register and output registers.
// TESTING  (DATA_WIDTH=16, RX_WIDTH=8, NUM_REGS=16, TIMEOUT_CYCLES=50)
//  1. chunks 0x03,0x34,0x12 -> reg_wr one cycle after 3rd strobe, reg_addr=3, reg_data=0x1234.
//  2. chunk 0xFF in idle -> rqst_regs one cycle later, busy stays 0, no reg_wr.
//  3. chunks 0x20,0xAA,0xBB -> err_addr pulse, no reg_wr, reg_addr/reg_data keep prior values.
//  4. 0x05,0x11 then 50 idle cycles -> err_timeout pulse, busy=0; then 0x05,0x22,0x33 ->
//     reg_wr, addr 5, data 0x3322 (stale 0x11 not used).
//  5. 0x05,0x11 then rst mid-cycle -> all outputs 0 immediately, no reg_wr; following frame
//     0x01,0xCD,0xAB writes 0xABCD to addr 1.
//  6. six strobes on consecutive cycles 0x00,0x01,0x02,0x01,0x03,0x04 -> two reg_wr pulses:
//     addr0=0x0201, addr1=0x0403; also 0x02,0xFF,0xFF writes 0xFFFF to addr 2, no rqst_regs.

Source files
------------

// File: rtl/conf_cmd_receiver_pkg.sv
// Shared definitions for the configuration command receiver.
//   rx_state_e       : receiver FSM state encoding (ST_IDLE=0, ST_DATA=1)
//   DEF_*            : default parameter values used by the top level
package conf_cmd_receiver_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } rx_state_e;

  localparam int          DEF_NUM_REGS       = 16;
  localparam int          DEF_DATA_WIDTH     = 16;
  localparam int          DEF_RX_WIDTH       = 8;
  localparam int          DEF_ADDR_WIDTH     = 4;
  localparam logic [7:0]  DEF_RQST_ADDR      = 8'hFF;
  localparam int          DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/conf_rx_timer.sv
// Inter-chunk idle timer.
//   clk, rst  : clock and asynchronous active-high reset
//   clear_i   : force the count back to zero (has priority over enable_i)
//   enable_i  : count one idle cycle
//   expired_o : count has reached TIMEOUT_CYCLES-1 (the last allowed idle cycle)
module conf_rx_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            TW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/conf_cmd_receiver.sv
// Host-to-device configuration command receiver.
// Assembles one address chunk plus DATA_WIDTH/RX_WIDTH data chunks (LSB chunk first)
// into a register write. The reserved address RQST_ADDR seen while idle requests a
// register dump instead of opening a frame.
//   clk, rst     : clock, asynchronous active-high reset
//   rx_data/rx_rdy : incoming chunk and its one-cycle strobe (always accepted)
//   reg_addr/reg_data/reg_wr : register write port; addr/data hold between writes
//   rqst_regs    : one-cycle dump request pulse
//   err_addr     : one-cycle pulse, completed frame had an out-of-range address
//   err_timeout  : one-cycle pulse, frame abandoned after too long without a chunk
//   busy         : a frame is in progress
//   dbg_state    : current FSM state, for observation only
//
// Handshake: rx_rdy is a valid strobe with no ready path; every cycle with rx_rdy=1
// delivers exactly one chunk on rx_data, which is consumed on that clock edge.
module conf_cmd_receiver
  import conf_cmd_receiver_pkg::*;
#(
  parameter int                  NUM_REGS       = DEF_NUM_REGS,
  parameter int                  DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int                  RX_WIDTH       = DEF_RX_WIDTH,
  parameter int                  ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter logic [RX_WIDTH-1:0] RQST_ADDR      = DEF_RQST_ADDR,
  parameter int                  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RX_WIDTH-1:0]   rx_data,
  input  logic                  rx_rdy,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_data,
  output logic                  reg_wr,
  output logic                  rqst_regs,
  output logic                  err_addr,
  output logic                  err_timeout,
  output logic                  busy,
  output rx_state_e             dbg_state
);

  localparam int                CHUNKS   = DATA_WIDTH / RX_WIDTH;
  localparam int                CW       = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0]     LAST_CNT = CW'(CHUNKS - 1);
  localparam logic [RX_WIDTH:0] NREGS_W  = (RX_WIDTH + 1)'(NUM_REGS);

  rx_state_e             state_q, state_d;
  logic [RX_WIDTH-1:0]   addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0] reg_data_q, reg_data_d;
  logic                  reg_wr_q, reg_wr_d;
  logic                  rqst_q, rqst_d;
  logic                  err_addr_q, err_addr_d;
  logic                  err_to_q, err_to_d;

  logic                  tmr_clear;
  logic                  tmr_en;
  logic                  tmr_expired;
  logic [DATA_WIDTH-1:0] rx_ext;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  addr_ok;

  conf_rx_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmr_clear),
    .enable_i (tmr_en),
    .expired_o(tmr_expired)
  );

  // New chunk enters at the top; after CHUNKS shifts the first chunk sits at the LSBs.
  assign rx_ext  = DATA_WIDTH'(rx_data);
  assign shifted = (shift_q >> RX_WIDTH) | (rx_ext << (DATA_WIDTH - RX_WIDTH));
  // Full address chunk is range-checked, not just the bits that reach reg_addr.
  assign addr_ok = ({1'b0, addr_q} < NREGS_W);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    reg_wr_d   = 1'b0;
    rqst_d     = 1'b0;
    err_addr_d = 1'b0;
    err_to_d   = 1'b0;
    tmr_clear  = 1'b1;
    tmr_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_rdy) begin
          if (rx_data == RQST_ADDR) begin
            rqst_d = 1'b1;
          end else begin
            addr_d  = rx_data;
            cnt_d   = LAST_CNT;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        tmr_clear = rx_rdy;
        tmr_en    = ~rx_rdy;
        if (rx_rdy) begin
          // A chunk in the expiry cycle is still taken; timeout only on a silent cycle.
          shift_d = shifted;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d = ST_IDLE;
            if (addr_ok) begin
              reg_wr_d   = 1'b1;
              reg_addr_d = addr_q[ADDR_WIDTH-1:0];
              reg_data_d = shifted;
            end else begin
              err_addr_d = 1'b1;
            end
          end
        end else if (tmr_expired) begin
          state_d  = ST_IDLE;
          err_to_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      reg_wr_q   <= 1'b0;
      rqst_q     <= 1'b0;
      err_addr_q <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      reg_wr_q   <= reg_wr_d;
      rqst_q     <= rqst_d;
      err_addr_q <= err_addr_d;
      err_to_q   <= err_to_d;
    end
  end

  assign reg_addr    = reg_addr_q;
  assign reg_data    = reg_data_q;
  assign reg_wr      = reg_wr_q;
  assign rqst_regs   = rqst_q;
  assign err_addr    = err_addr_q;
  assign err_timeout = err_to_q;
  assign busy        = (state_q == ST_DATA);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_conf_cmd_receiver.sv
// Testbench for conf_cmd_receiver (DATA_WIDTH=16, RX_WIDTH=8, NUM_REGS=16, TIMEOUT=50).
// The reference model keeps the open frame as a queue of received chunks and an idle
// counter; every cycle all outputs are compared against it as one packed vector.
module tb_conf_cmd_receiver;
  import conf_cmd_receiver_pkg::*;

  localparam int NREGS   = 16;
  localparam int DW      = 16;
  localparam int RW      = 8;
  localparam int AW      = 4;
  localparam int TIMEOUT = 50;
  localparam int NCHUNK  = DW / RW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [RW-1:0] rx_data = '0;
  logic          rx_rdy  = 1'b0;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_data;
  logic          reg_wr, rqst_regs, err_addr, err_timeout, busy;
  rx_state_e     dbg_state;

  conf_cmd_receiver #(
    .NUM_REGS      (NREGS),
    .DATA_WIDTH    (DW),
    .RX_WIDTH      (RW),
    .ADDR_WIDTH    (AW),
    .RQST_ADDR     (8'hFF),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .reg_addr   (reg_addr),
    .reg_data   (reg_data),
    .reg_wr     (reg_wr),
    .rqst_regs  (rqst_regs),
    .err_addr   (err_addr),
    .err_timeout(err_timeout),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- reference model ----------------
  logic [RW-1:0] frame_q[$];
  int            idle_cnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_wr, m_rq, m_ea, m_et;

  int checks = 0;
  int errors = 0;
  int n_wr   = 0;

  // {reg_wr, rqst_regs, err_addr, err_timeout, busy, state, reg_addr, reg_data}
  logic [25:0] obs_v;
  logic [25:0] exp_v;
  assign obs_v = {reg_wr, rqst_regs, err_addr, err_timeout, busy, dbg_state == ST_DATA, reg_addr, reg_data};
  assign exp_v = {m_wr, m_rq, m_ea, m_et, frame_q.size() != 0, frame_q.size() != 0, m_addr, m_data};

  task automatic model_reset();
    frame_q.delete();
    idle_cnt = 0;
    m_addr = '0;
    m_data = '0;
    {m_wr, m_rq, m_ea, m_et} = 4'b0;
  endtask

  task automatic model_step(input logic rdy, input logic [RW-1:0] d);
    logic [RW-1:0] a;
    logic [DW-1:0] word;
    {m_wr, m_rq, m_ea, m_et} = 4'b0;
    if (rdy) begin
      idle_cnt = 0;
      if (frame_q.size() == 0 && d == 8'hFF) begin
        m_rq = 1'b1;
      end else begin
        frame_q.push_back(d);
        if (frame_q.size() == 1 + NCHUNK) begin
          a = frame_q[0];
          word = '0;
          for (int i = 0; i < NCHUNK; i++) word = word + (DW'(frame_q[i+1]) << (RW * i));
          if (int'(a) < NREGS) begin
            m_wr = 1'b1;
            m_addr = a[AW-1:0];
            m_data = word;
          end else begin
            m_ea = 1'b1;
          end
          frame_q.delete();
        end
      end
    end else if (frame_q.size() != 0) begin
      idle_cnt++;
      if (idle_cnt == TIMEOUT) begin
        m_et = 1'b1;
        frame_q.delete();
        idle_cnt = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Drive at negedge, model the following posedge, sample 1 ns after it.
  task automatic tick(input logic rdy, input logic [RW-1:0] d);
    @(negedge clk);
    rx_rdy  = rdy;
    rx_data = rdy ? d : RW'($urandom_range(0, 255));
    @(posedge clk);
    model_step(rdy, d);
    #1;
    if (reg_wr) n_wr++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #2;
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs_v, exp_v);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write();
    logic [RW-1:0] s[3] = '{8'h03, 8'h34, 8'h12};
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, s[i]);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL write c%0d: got %h want %h", i, obs_v, exp_v);
      end
    end
    tick(1'b0, 8'h00);
    checks++;
    if (reg_addr !== 4'd3 || reg_data !== 16'h1234 || reg_wr !== 1'b0) begin
      errors++;
      $display("FAIL write_hold: got addr %h data %h wr %b want 3 1234 0", reg_addr, reg_data, reg_wr);
    end
  endtask

  task automatic test_rqst();
    for (int i = 0; i < 3; i++) begin
      tick(i == 0, 8'hFF);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL rqst c%0d: got %h want %h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_addr_err();
    logic [RW-1:0] s[4] = '{8'h20, 8'hAA, 8'hBB, 8'h00};
    for (int i = 0; i < 4; i++) begin
      tick(i < 3, s[i]);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL addr_err c%0d: got %h want %h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_timeout();
    tick(1'b1, 8'h05);
    tick(1'b1, 8'h11);
    for (int i = 0; i < TIMEOUT + 2; i++) begin
      tick(1'b0, 8'h00);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL timeout idle%0d: got %h want %h", i, obs_v, exp_v);
      end
    end
    tick(1'b1, 8'h05);
    tick(1'b1, 8'h22);
    tick(1'b1, 8'h33);
    checks++;
    if (obs_v !== exp_v || reg_data !== 16'h3322) begin
      errors++;
      $display("FAIL timeout_refill: got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [RW-1:0] s[3] = '{8'h01, 8'hCD, 8'hAB};
    tick(1'b1, 8'h05);
    tick(1'b1, 8'h11);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL reset_mid: got %h want %h", obs_v, exp_v);
    end
    @(negedge clk);
    rx_rdy = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, s[i]);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset_refill c%0d: got %h want %h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] s[9] = '{8'h00, 8'h01, 8'h02, 8'h01, 8'h03, 8'h04, 8'h02, 8'hFF, 8'hFF};
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, s[i]);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL b2b c%0d: got %h want %h", i, obs_v, exp_v);
      end
    end
    checks++;
    if (reg_addr !== 4'd2 || reg_data !== 16'hFFFF) begin
      errors++;
      $display("FAIL b2b_ffff: got addr %h data %h want 2 ffff", reg_addr, reg_data);
    end
  endtask

  task automatic test_random();
    int gap;
    logic [RW-1:0] d;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       gap = $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
        1, 2:    gap = $urandom_range(1, 4);
        default: gap = 0;
      endcase
      for (int g = 0; g < gap; g++) begin
        tick(1'b0, 8'h00);
        checks++;
        if (obs_v !== exp_v) begin
          errors++;
          $display("FAIL random n%0d gap%0d: got %h want %h", n, g, obs_v, exp_v);
        end
      end
      case ($urandom_range(0, 7))
        0:       d = 8'hFF;
        1:       d = RW'($urandom_range(16, 254));
        default: d = RW'($urandom_range(0, 15));
      endcase
      if (frame_q.size() != 0) d = RW'($urandom_range(0, 255));
      tick(1'b1, d);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL random n%0d: got %h want %h", n, obs_v, exp_v);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    model_reset();
    test_reset();
    test_write();
    test_rqst();
    test_addr_err();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    checks++;
    if (n_wr < 10) begin
      errors++;
      $display("FAIL write_count: got %0d writes want at least 10", n_wr);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
